// File: rtl/seg_scan_counter.sv
// seg_scan_counter: enable-gated BCD up/down counter with a multiplexed,
// active-low seven-segment scan output.
//
// Optional build macro: SEG_BLANK_LEADING_EN blanks leading-zero digits
// (digit 0 is always shown). When the macro is undefined, every digit is
// displayed, including leading zeros.
module seg_scan_counter #(
  parameter int unsigned DIGITS      = 6,
  parameter int unsigned TICK_CYCLES = 2_500_000,
  parameter int unsigned SCAN_CYCLES = 50_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              up,
  input  logic              clr,
  output logic [DIGITS-1:0] sel,
  output logic [7:0]        seg,
  output logic              wrap
);

  localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int unsigned IW = (DIGITS > 1)      ? $clog2(DIGITS)      : 1;

  localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [SW-1:0]     SCAN_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] SEL_RST   = ~(DIGITS'(1));

  // Active-low segment code {dp,g,f,e,d,c,b,a}; dp is always off.
  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] c;
    case (d)
      4'd0:    c = 8'hC0;
      4'd1:    c = 8'hF9;
      4'd2:    c = 8'hA4;
      4'd3:    c = 8'hB0;
      4'd4:    c = 8'h99;
      4'd5:    c = 8'h92;
      4'd6:    c = 8'h82;
      4'd7:    c = 8'hF8;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h90;
      default: c = 8'hFF;
    endcase
    return c;
  endfunction

  logic [TW-1:0]            tick_cnt_q, tick_cnt_d;
  logic [DIGITS-1:0][3:0]   digits_q, digits_d;
  logic [DIGITS-1:0][3:0]   bcd_step;
  logic                     wrap_q, wrap_d;
  logic                     tick;
  logic                     carry;

  logic [SW-1:0]            scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [DIGITS-1:0]        sel_q, sel_d;
  logic [7:0]               seg_q, seg_d;
  logic                     scan_last;

  // Tick generation: counter only moves while enabled; clear overrides it.
  always_comb begin
    tick       = en && (tick_cnt_q == TICK_LAST) && !clr;
    tick_cnt_d = tick_cnt_q;
    if (clr) begin
      tick_cnt_d = '0;
    end else if (en) begin
      tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TW'(1);
    end
  end

  // Decimal increment/decrement ripple; a carry out of the top digit is a wrap.
  always_comb begin
    bcd_step = digits_q;
    carry    = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (up) begin
          if (digits_q[i] == 4'd9) begin
            bcd_step[i] = 4'd0;
          end else begin
            bcd_step[i] = digits_q[i] + 4'd1;
            carry       = 1'b0;
          end
        end else begin
          if (digits_q[i] == 4'd0) begin
            bcd_step[i] = 4'd9;
          end else begin
            bcd_step[i] = digits_q[i] - 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
  end

  // Next digit value and wrap pulse; tick already excludes clear.
  always_comb begin
    digits_d = digits_q;
    wrap_d   = 1'b0;
    if (clr) begin
      digits_d = '0;
    end else if (tick) begin
      digits_d = bcd_step;
      wrap_d   = carry;
    end
  end

`ifdef SEG_BLANK_LEADING_EN
  logic [DIGITS-1:0] hi_zero;

  // hi_zero[i]: digit i and every digit above it are zero.
  always_comb begin
    hi_zero = '0;
    hi_zero[DIGITS-1] = (digits_q[DIGITS-1] == 4'd0);
    for (int unsigned k = 1; k < DIGITS; k++) begin
      hi_zero[DIGITS-1-k] = hi_zero[DIGITS-k] && (digits_q[DIGITS-1-k] == 4'd0);
    end
  end
`endif

  // Free-running scan: index, select and segment code change together, with
  // the code taken from the newly selected digit's current value.
  always_comb begin
    scan_last  = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d = scan_last ? '0 : scan_cnt_q + SW'(1);
    idx_d      = idx_q;
    sel_d      = sel_q;
    seg_d      = seg_q;
    if (scan_last) begin
      idx_d        = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      sel_d        = '1;
      sel_d[idx_d] = 1'b0;
      seg_d        = seg_code(digits_q[idx_d]);
`ifdef SEG_BLANK_LEADING_EN
      if ((idx_d != '0) && hi_zero[idx_d]) begin
        seg_d = 8'hFF;
      end
`endif
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_q <= '0;
      digits_q   <= '0;
      wrap_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      digits_q   <= digits_d;
      wrap_q     <= wrap_d;
    end
  end

  // Scan state registers, independent of enable and clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
      sel_q      <= SEL_RST;
      seg_q      <= 8'hC0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      sel_q      <= sel_d;
      seg_q      <= seg_d;
    end
  end

  assign sel  = sel_q;
  assign seg  = seg_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_seg_scan_counter.sv
// tb_seg_scan_counter: directed checks of seg_scan_counter with
// DIGITS=2, TICK_CYCLES=4, SCAN_CYCLES=3.
module tb_seg_scan_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up;
  logic       clr;
  logic [1:0] sel;
  logic [7:0] seg;
  logic       wrap;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  seg_scan_counter #(
    .DIGITS     (2),
    .TICK_CYCLES(4),
    .SCAN_CYCLES(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .up  (up),
    .clr (clr),
    .sel (sel),
    .seg (seg),
    .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        up;
    logic        clr;
    int unsigned ncyc;
    logic [1:0]  sel;
    logic [7:0]  seg;
    logic [7:0]  val;
    logic        wrap;
  } vec_t;

  vec_t tbl[13];

  function automatic logic [7:0] cur_val();
    logic [7:0] v;
    v = dut.digits_q;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] prev_sel;
    logic       seen10, seen01, saw_d0, saw_d1;
    logic [7:0] exp_blank;

    // Count-up from reset: value steps every 4 edges, scan every 3 edges.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 0, 2'b10, 8'hC0, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 3, 2'b01, 8'hC0, 8'h00, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1, 2'b01, 8'hC0, 8'h01, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 2, 2'b10, 8'hF9, 8'h01, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 3, 2'b01, 8'hC0, 8'h02, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 3, 2'b10, 8'hA4, 8'h03, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 6, 2'b10, 8'h99, 8'h04, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 6, 2'b10, 8'h92, 8'h06, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 6, 2'b10, 8'hF8, 8'h07, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 6, 2'b10, 8'h80, 8'h09, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 4, 2'b01, 8'hC0, 8'h10, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 2, 2'b10, 8'hC0, 8'h10, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 3, 2'b01, 8'hF9, 8'h11, 1'b0};

    rst = 1'b0; en = 1'b1; up = 1'b1; clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      en = tbl[i].en; up = tbl[i].up; clr = tbl[i].clr;
      step(tbl[i].ncyc);
      chk($sformatf("tbl%0d_sel", i), 32'(sel), 32'(tbl[i].sel));
      chk($sformatf("tbl%0d_seg", i), 32'(seg), 32'(tbl[i].seg));
      chk($sformatf("tbl%0d_val", i), 32'(cur_val()), 32'(tbl[i].val));
      chk($sformatf("tbl%0d_wrap", i), 32'(wrap), 32'(tbl[i].wrap));
    end

    // Down-wrap 00 -> 99, then up-wrap 99 -> 00 with up toggled between ticks.
    clr = 1'b1; up = 1'b0;
    step(1);
    chk("clr_val", 32'(cur_val()), 32'h00);
    clr = 1'b0;
    step(3);
    chk("dn_pre_val", 32'(cur_val()), 32'h00);
    chk("dn_pre_wrap", 32'(wrap), 32'd0);
    step(1);
    chk("dn_wrap_val", 32'(cur_val()), 32'h99);
    chk("dn_wrap_pulse", 32'(wrap), 32'd1);
    step(1);
    chk("dn_wrap_end", 32'(wrap), 32'd0);
    chk("dn_hold_val", 32'(cur_val()), 32'h99);
    up = 1'b1; step(1);
    up = 1'b0; step(1);
    up = 1'b1; step(1);
    chk("up_wrap_val", 32'(cur_val()), 32'h00);
    chk("up_wrap_pulse", 32'(wrap), 32'd1);
    step(1);
    chk("up_wrap_end", 32'(wrap), 32'd0);

    // Clear coinciding with a tick at 37.
    clr = 1'b1; step(1);
    clr = 1'b0; up = 1'b1;
    step(148);
    chk("reach37", 32'(cur_val()), 32'h37);
    step(3);
    chk("pre_tick37", 32'(cur_val()), 32'h37);
    clr = 1'b1; step(1);
    chk("clr_tick_val", 32'(cur_val()), 32'h00);
    chk("clr_tick_wrap", 32'(wrap), 32'd0);
    chk("clr_tick_tc", 32'(dut.tick_cnt_q), 32'd0);
    clr = 1'b0;
    step(3);
    chk("clr_restart_hold", 32'(cur_val()), 32'h00);
    step(1);
    chk("clr_restart_step", 32'(cur_val()), 32'h01);

    // Enable low for 10 cycles mid-period.
    step(2);
    en = 1'b0;
    seen10 = 1'b0; seen01 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk($sformatf("freeze_val%0d", i), 32'(cur_val()), 32'h01);
      if (sel == 2'b10) seen10 = 1'b1;
      if (sel == 2'b01) seen01 = 1'b1;
    end
    chk("freeze_tc", 32'(dut.tick_cnt_q), 32'd2);
    chk("freeze_scan_both", 32'({seen10, seen01}), 32'b11);
    chk("freeze_seg", 32'(seg), (sel == 2'b10) ? 32'hF9 : 32'hC0);
    en = 1'b1;
    step(1);
    chk("resume_hold", 32'(cur_val()), 32'h01);
    step(1);
    chk("resume_step", 32'(cur_val()), 32'h02);

    // Value 05: digit 1 shows 0 or blank depending on the build macro.
`ifdef SEG_BLANK_LEADING_EN
    exp_blank = 8'hFF;
`else
    exp_blank = 8'hC0;
`endif
    clr = 1'b1; step(1);
    clr = 1'b0;
    step(20);
    chk("reach05", 32'(cur_val()), 32'h05);
    en = 1'b0;
    prev_sel = sel;
    saw_d0 = 1'b0; saw_d1 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(1);
      if (sel != prev_sel) begin
        if (sel == 2'b01) begin
          saw_d1 = 1'b1;
          chk("blank_d1_seg", 32'(seg), 32'(exp_blank));
        end else begin
          saw_d0 = 1'b1;
          chk("blank_d0_seg", 32'(seg), 32'h92);
        end
      end
      prev_sel = sel;
    end
    chk("blank_both_digits", 32'({saw_d1, saw_d0}), 32'b11);

    // Asynchronous reset mid-scan at 42.
    en = 1'b1;
    clr = 1'b1; step(1);
    clr = 1'b0;
    step(168);
    chk("reach42", 32'(cur_val()), 32'h42);
    step(1);
    #2 rst = 1'b0;
    #1;
    chk("arst_sel", 32'(sel), 32'b10);
    chk("arst_seg", 32'(seg), 32'hC0);
    chk("arst_wrap", 32'(wrap), 32'd0);
    chk("arst_val", 32'(cur_val()), 32'h00);
    chk("arst_tc", 32'(dut.tick_cnt_q), 32'd0);
    step(2);
    chk("arst_hold_sel", 32'(sel), 32'b10);
    @(negedge clk);
    rst = 1'b1;
    step(3);
    chk("post_rst_sel", 32'(sel), 32'b01);
    chk("post_rst_seg", 32'(seg), 32'hC0);
    chk("post_rst_val", 32'(cur_val()), 32'h00);
    step(1);
    chk("post_rst_step", 32'(cur_val()), 32'h01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
